rv_instr_stim_gen: RTL and testbench
====================================

RV_INSTR_STIM_GEN -- requirements
Module: rv_instr_stim_gen

Interface
REQ-001 SHALL have parameter SEED, default 32'h0001_17E4, meaning LFSR reset value; must be nonzero.
REQ-002 SHALL have parameter REG_BITS, default 5, meaning register-field width used (1..5); upper register-field bits are forced 0.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of instruction budget and issued counter.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin a burst; honoured in IDLE or DONE only.
REQ-007 SHALL have port mode_en  input  4  class enables: bit0 I-type ALU, bit1 R-type ALU, bit2 LUI, bit3 AUIPC; latched on accepted start.
REQ-008 SHALL have port num_instr  input  CNT_W  burst length, latched on accepted start; 0 means unlimited.
REQ-009 SHALL have port instr_ready  input  1  consumer accepts instr this cycle.
REQ-010 SHALL have port instr_valid  output  1  instr holds a generated instruction.
REQ-011 SHALL have port instr  output  32  RV32I instruction word.
REQ-012 SHALL have port done  output  1  burst complete.
REQ-013 SHALL have port issued_count  output  CNT_W  handshakes in current burst.

Function
REQ-014 SHALL implement FSM IDLE/RUN/DONE; IDLE->RUN and DONE->RUN on start; RUN->DONE on the handshake making issued_count equal a nonzero latched num_instr; no other transitions except reset.
REQ-015 SHALL define handshake as instr_valid && instr_ready; instr_valid = 1 only in RUN; done = 1 only in DONE.
REQ-016 SHALL output instr = 32'h00000013 (NOP) whenever not in RUN.
REQ-017 SHALL keep a 32-bit Galois LFSR, taps 32'h80200003 (x^32+x^22+x^2+x+1), stepping once per handshake and once on accepted start; no other step.
REQ-018 SHALL derive instr combinationally from the registered LFSR and latched mode_en, so instr is stable while instr_valid && !instr_ready.
REQ-019 SHALL map fields from LFSR L: class L[1:0], funct3 L[4:2], rd L[9:5], rs1 L[14:10], rs2 L[19:15], imm12 L[31:20], imm20 L[31:12].
REQ-020 SHALL mask each register field to its low REG_BITS bits.
REQ-021 SHALL, if class bit not set in mode_en, substitute the lowest-index enabled class; if mode_en = 0, emit NOP with instr_valid still 1.
REQ-022 SHALL encode I-type as {imm12, rs1, funct3, rd, 7'h13}; funct3=1 forces imm12[11:5]=0; funct3=5 forces imm12[11:5]={1'b0, L[30], 5'b0}.
REQ-023 SHALL encode R-type as {funct7, rs2, rs1, funct3, rd, 7'h33}; funct7={1'b0, L[30], 5'b0} when funct3 is 0 or 5, else 7'h00.
REQ-024 SHALL encode LUI as {imm20, rd, 7'h37} and AUIPC as {imm20, rd, 7'h17}.
REQ-025 SHALL increment issued_count by 1 per handshake, clear it to 0 on accepted start, and wrap modulo 2^CNT_W in unlimited mode without leaving RUN.
REQ-026 SHALL ignore start while in RUN; mode_en/num_instr changes mid-burst have no effect.
REQ-027 SHALL NOT reseed the LFSR on start; consecutive bursts continue the sequence.

Reset
REQ-028 SHALL on reset enter IDLE, set LFSR=SEED, issued_count=0, instr_valid=0, done=0, instr=32'h00000013, latched mode_en=0, latched num_instr=0.
REQ-029 SHALL give reset priority over start and handshake in the same cycle, including mid-burst.

Verification
REQ-030 Reset held 3 cycles -> instr=0x00000013, instr_valid=0, done=0, issued_count=0 each cycle.
REQ-031 start with mode_en=4'b0001, num_instr=3, instr_ready=1 -> exactly 3 handshakes, all instr[6:0]=0x13, done=1 the cycle after the third, issued_count=3.
REQ-032 instr_ready=0 for 5 cycles in RUN -> instr and issued_count unchanged all 5 cycles; first instruction after ready rises equals the stalled one.
REQ-033 1000 I-type instructions -> funct3=1 always has instr[31:25]=0x00; funct3=5 has instr[31:25] in {0x00,0x20}; R-type funct3 in {1,2,3,4,6,7} has funct7=0x00.
REQ-034 REG_BITS=2, mode_en=4'b1111 -> every rd/rs1/rs2 field below 4; each of opcodes 0x13,0x33,0x37,0x17 appears within 200 instructions.
REQ-035 Reset after 2 handshakes, then start with identical inputs -> instruction sequence identical to the first run from its first word.

Source files
------------

// File: rtl/rv_instr_stim_gen.sv
// rtl/rv_instr_stim_gen.sv - LFSR-driven RV32I ALU/LUI/AUIPC instruction stimulus generator
module rv_instr_stim_gen #(
  parameter logic [31:0] SEED     = 32'h0001_17E4,
  parameter int          REG_BITS = 5,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mode_en,
  input  logic [CNT_W-1:0] num_instr,
  input  logic             instr_ready,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic             done,
  output logic [CNT_W-1:0] issued_count
);

  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [4:0]  REG_MASK = 5'((32'd1 << REG_BITS) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_step;
  logic [3:0]         mode_q;
  logic [CNT_W-1:0]   num_q, cnt_q, cnt_inc;
  logic               start_acc, hs;

  assign start_acc = start && (state_q != S_RUN);
  assign hs        = (state_q == S_RUN) && instr_ready;
  assign cnt_inc   = cnt_q + 1'b1;
  // Right-shifting Galois form: feedback bit L[0] folds into the tap mask.
  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN:          if (hs && (num_q != '0) && (cnt_inc == num_q)) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      mode_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        lfsr_q <= lfsr_step;
        mode_q <= mode_en;
        num_q  <= num_instr;
        cnt_q  <= '0;
      end else if (hs) begin
        lfsr_q <= lfsr_step;
        cnt_q  <= cnt_inc;
      end
    end
  end

  logic [1:0]  cls, eff_cls;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm12;
  logic [6:0]  funct7;
  logic [31:0] gen_word;

  always_comb begin
    cls    = lfsr_q[1:0];
    funct3 = lfsr_q[4:2];
    rd     = lfsr_q[9:5]   & REG_MASK;
    rs1    = lfsr_q[14:10] & REG_MASK;
    rs2    = lfsr_q[19:15] & REG_MASK;
    imm12  = lfsr_q[31:20];
    if (funct3 == 3'd1)      imm12[11:5] = 7'h00;
    else if (funct3 == 3'd5) imm12[11:5] = {1'b0, lfsr_q[30], 5'b0};
    funct7 = ((funct3 == 3'd0) || (funct3 == 3'd5)) ? {1'b0, lfsr_q[30], 5'b0} : 7'h00;

    // Disabled classes fall back to the lowest-index enabled class.
    if (mode_q[cls])     eff_cls = cls;
    else if (mode_q[0])  eff_cls = 2'd0;
    else if (mode_q[1])  eff_cls = 2'd1;
    else if (mode_q[2])  eff_cls = 2'd2;
    else                 eff_cls = 2'd3;

    case (eff_cls)
      2'd0:    gen_word = {imm12, rs1, funct3, rd, 7'h13};
      2'd1:    gen_word = {funct7, rs2, rs1, funct3, rd, 7'h33};
      2'd2:    gen_word = {lfsr_q[31:12], rd, 7'h37};
      default: gen_word = {lfsr_q[31:12], rd, 7'h17};
    endcase
    if (mode_q == 4'b0000) gen_word = NOP;
  end

  assign instr_valid  = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign instr        = instr_valid ? gen_word : NOP;
  assign issued_count = cnt_q;

endmodule

// File: tb/tb_rv_instr_stim_gen.sv
// tb/tb_rv_instr_stim_gen.sv - directed self-checking bench for rv_instr_stim_gen
module tb_rv_instr_stim_gen;

  localparam logic [31:0] SEED = 32'h0001_17E4;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, instr_ready = 1'b0;
  logic [3:0]  mode_en = 4'h0;
  logic [15:0] num_instr = 16'd0;
  logic        instr_valid, done;
  logic [31:0] instr;
  logic [15:0] issued_count;

  logic        r2 = 1'b1, s2 = 1'b0, rdy2 = 1'b0;
  logic [3:0]  mode2 = 4'h0, num2 = 4'd0;
  logic        valid2, done2;
  logic [31:0] instr2;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;
  logic [31:0] m1, m2;

  always #5 clk = ~clk;

  rv_instr_stim_gen dut (
    .clk(clk), .reset(reset), .start(start), .mode_en(mode_en), .num_instr(num_instr),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr), .done(done),
    .issued_count(issued_count)
  );

  rv_instr_stim_gen #(.REG_BITS(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(r2), .start(s2), .mode_en(mode2), .num_instr(num2),
    .instr_ready(rdy2), .instr_valid(valid2), .instr(instr2), .done(done2),
    .issued_count(cnt2)
  );

  function automatic logic [31:0] nxt(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] l, input logic [3:0] m, input int rb);
    logic [1:0]  c;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    if (m == 4'h0) return NOP;
    c = l[1:0];
    if (!m[c]) begin
      c = 2'd0;
      while (!m[c]) c = c + 2'd1;
    end
    rd  = 5'(int'(l[9:5])   % (1 << rb));
    rs1 = 5'(int'(l[14:10]) % (1 << rb));
    rs2 = 5'(int'(l[19:15]) % (1 << rb));
    f3  = l[4:2];
    imm = l[31:20];
    if (f3 == 3'd1) imm[11:5] = 7'h00;
    if (f3 == 3'd5) imm[11:5] = l[30] ? 7'h20 : 7'h00;
    f7 = ((f3 == 3'd0 || f3 == 3'd5) && l[30]) ? 7'h20 : 7'h00;
    case (c)
      2'd0:    return {imm, rs1, f3, rd, 7'h13};
      2'd1:    return {f7, rs2, rs1, f3, rd, 7'h33};
      2'd2:    return {l[31:12], rd, 7'h37};
      default: return {l[31:12], rd, 7'h17};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; r2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, NOP); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", issued_count); end
    end
    m1 = SEED;
  endtask

  task automatic test_burst();
    reset = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL idle_out got v=%b %h exp v=0 %h", instr_valid, instr, NOP); end
    start = 1'b1; mode_en = 4'b0001; num_instr = 16'd3; instr_ready = 1'b1;
    tick();
    start = 1'b0; m1 = nxt(m1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL burst_valid[%0d] got %b exp 1", i, instr_valid); end
      checks++; if (instr !== exp_instr(m1, 4'b0001, 5)) begin errors++; $display("FAIL burst_instr[%0d] got %h exp %h", i, instr, exp_instr(m1, 4'b0001, 5)); end
      checks++; if (instr[6:0] !== 7'h13) begin errors++; $display("FAIL burst_opcode[%0d] got %h exp 13", i, instr[6:0]); end
      if (i == 1) begin start = 1'b1; num_instr = 16'd9; mode_en = 4'b0010; end
      tick();
      start = 1'b0; m1 = nxt(m1);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL burst_done got %b exp 1", done); end
    checks++; if (issued_count !== 16'd3) begin errors++; $display("FAIL burst_count got %0d exp 3", issued_count); end
    checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL burst_post got v=%b %h exp v=0 %h", instr_valid, instr, NOP); end
  endtask

  task automatic test_stall();
    logic [31:0] stalled;
    start = 1'b1; mode_en = 4'b0010; num_instr = 16'd4; instr_ready = 1'b0;
    tick();
    start = 1'b0; m1 = nxt(m1);
    stalled = instr;
    checks++; if (stalled !== exp_instr(m1, 4'b0010, 5)) begin errors++; $display("FAIL stall_first got %h exp %h", stalled, exp_instr(m1, 4'b0010, 5)); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (instr !== stalled) begin errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i, instr, stalled); end
      checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL stall_count[%0d] got %0d exp 0", i, issued_count); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, instr_valid); end
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr !== exp_instr(m1, 4'b0010, 5)) begin errors++; $display("FAIL stall_seq[%0d] got %h exp %h", i, instr, exp_instr(m1, 4'b0010, 5)); end
      checks++; if (issued_count !== 16'(i)) begin errors++; $display("FAIL stall_cnt[%0d] got %0d exp %0d", i, issued_count, i); end
      tick();
      m1 = nxt(m1);
    end
    checks++; if (done !== 1'b1 || issued_count !== 16'd4) begin errors++; $display("FAIL stall_done got d=%b c=%0d exp d=1 c=4", done, issued_count); end
  endtask

  task automatic test_field_rules();
    start = 1'b1; mode_en = 4'b0001; num_instr = 16'd1000; instr_ready = 1'b1;
    tick();
    start = 1'b0; m1 = nxt(m1);
    for (int i = 0; i < 1000; i++) begin
      checks++; if (instr !== exp_instr(m1, 4'b0001, 5)) begin errors++; $display("FAIL itype_instr[%0d] got %h exp %h", i, instr, exp_instr(m1, 4'b0001, 5)); end
      if (instr[14:12] == 3'd1) begin
        checks++; if (instr[31:25] !== 7'h00) begin errors++; $display("FAIL slli_upper[%0d] got %h exp 00", i, instr[31:25]); end
      end
      if (instr[14:12] == 3'd5) begin
        checks++; if (instr[31:25] !== 7'h00 && instr[31:25] !== 7'h20) begin errors++; $display("FAIL srli_upper[%0d] got %h exp 00 or 20", i, instr[31:25]); end
      end
      tick();
      m1 = nxt(m1);
    end
    checks++; if (done !== 1'b1 || issued_count !== 16'd1000) begin errors++; $display("FAIL itype_done got d=%b c=%0d exp d=1 c=1000", done, issued_count); end
    start = 1'b1; mode_en = 4'b0010; num_instr = 16'd200;
    tick();
    start = 1'b0; m1 = nxt(m1);
    for (int i = 0; i < 200; i++) begin
      checks++; if (instr !== exp_instr(m1, 4'b0010, 5)) begin errors++; $display("FAIL rtype_instr[%0d] got %h exp %h", i, instr, exp_instr(m1, 4'b0010, 5)); end
      if (instr[14:12] != 3'd0 && instr[14:12] != 3'd5) begin
        checks++; if (instr[31:25] !== 7'h00) begin errors++; $display("FAIL rtype_funct7[%0d] got %h exp 00", i, instr[31:25]); end
      end
      tick();
      m1 = nxt(m1);
    end
  endtask

  task automatic test_mode_zero();
    start = 1'b1; mode_en = 4'b0000; num_instr = 16'd2; instr_ready = 1'b1;
    tick();
    start = 1'b0; m1 = nxt(m1);
    for (int i = 0; i < 2; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr !== NOP) begin errors++; $display("FAIL zero_mode[%0d] got v=%b %h exp v=1 %h", i, instr_valid, instr, NOP); end
      tick();
      m1 = nxt(m1);
    end
    checks++; if (done !== 1'b1 || issued_count !== 16'd2) begin errors++; $display("FAIL zero_done got d=%b c=%0d exp d=1 c=2", done, issued_count); end
  endtask

  task automatic test_regbits_wrap();
    logic [3:0] seen;
    logic [6:0] op;
    seen = 4'b0;
    r2 = 1'b0; m2 = SEED;
    s2 = 1'b1; mode2 = 4'hF; num2 = 4'd0; rdy2 = 1'b1;
    tick();
    s2 = 1'b0; m2 = nxt(m2);
    for (int i = 0; i < 200; i++) begin
      op = instr2[6:0];
      checks++; if (instr2 !== exp_instr(m2, 4'hF, 2)) begin errors++; $display("FAIL rb2_instr[%0d] got %h exp %h", i, instr2, exp_instr(m2, 4'hF, 2)); end
      checks++; if (instr2[11:7] >= 5'd4) begin errors++; $display("FAIL rb2_rd[%0d] got %0d exp <4", i, instr2[11:7]); end
      if (op == 7'h13 || op == 7'h33) begin
        checks++; if (instr2[19:15] >= 5'd4) begin errors++; $display("FAIL rb2_rs1[%0d] got %0d exp <4", i, instr2[19:15]); end
      end
      if (op == 7'h33) begin
        checks++; if (instr2[24:20] >= 5'd4) begin errors++; $display("FAIL rb2_rs2[%0d] got %0d exp <4", i, instr2[24:20]); end
      end
      if (op == 7'h13) seen[0] = 1'b1;
      if (op == 7'h33) seen[1] = 1'b1;
      if (op == 7'h37) seen[2] = 1'b1;
      if (op == 7'h17) seen[3] = 1'b1;
      checks++; if (cnt2 !== 4'(i) || valid2 !== 1'b1) begin errors++; $display("FAIL wrap_cnt[%0d] got c=%0d v=%b exp c=%0d v=1", i, cnt2, valid2, i % 16); end
      tick();
      m2 = nxt(m2);
    end
    checks++; if (seen !== 4'b1111) begin errors++; $display("FAIL rb2_opcodes got %b exp 1111", seen); end
    r2 = 1'b1;
  endtask

  task automatic test_reset_replay();
    logic [31:0] first [2];
    reset = 1'b1;
    tick();
    reset = 1'b0; m1 = SEED;
    start = 1'b1; mode_en = 4'b1011; num_instr = 16'd5; instr_ready = 1'b1;
    tick();
    start = 1'b0; m1 = nxt(m1);
    for (int i = 0; i < 2; i++) begin
      first[i] = instr;
      checks++; if (instr !== exp_instr(m1, 4'b1011, 5)) begin errors++; $display("FAIL replay_a[%0d] got %h exp %h", i, instr, exp_instr(m1, 4'b1011, 5)); end
      tick();
      m1 = nxt(m1);
    end
    reset = 1'b1; start = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0 || issued_count !== 16'd0 || done !== 1'b0 || instr !== NOP) begin
      errors++; $display("FAIL mid_reset got v=%b c=%0d d=%b %h exp v=0 c=0 d=0 %h", instr_valid, issued_count, done, instr, NOP);
    end
    reset = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (instr !== first[i]) begin errors++; $display("FAIL replay_b[%0d] got %h exp %h", i, instr, first[i]); end
      tick();
    end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (done !== 1'b1 || issued_count !== 16'd5) begin errors++; $display("FAIL replay_done got d=%b c=%0d exp d=1 c=5", done, issued_count); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_stall();
    test_field_rules();
    test_mode_zero();
    test_regbits_wrap();
    test_reset_replay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
